// File: rtl/seq_core_pkg.sv
// seq_core_pkg: shared definitions for the seq_core sequencer.
//   - opcode constants for the 4-byte instruction set
//   - FSM state encoding
//   - byte offsets of the instruction fields within an instruction word
package seq_core_pkg;

  localparam logic [7:0] OP_NOP      = 8'd0;
  localparam logic [7:0] OP_MOVI     = 8'd1;
  localparam logic [7:0] OP_LD       = 8'd2;
  localparam logic [7:0] OP_MOV      = 8'd3;
  localparam logic [7:0] OP_ST       = 8'd4;
  localparam logic [7:0] OP_ADD      = 8'd10;
  localparam logic [7:0] OP_SUB      = 8'd11;
  localparam logic [7:0] OP_CMP      = 8'd12;
  localparam logic [7:0] OP_JMP      = 8'd13;
  localparam logic [7:0] OP_JZ       = 8'd14;
  localparam logic [7:0] OP_JNZ      = 8'd15;
  localparam logic [7:0] OP_EX_FIRST = 8'd20;
  localparam logic [7:0] OP_EX_LAST  = 8'd29;
  localparam logic [7:0] OP_DBG      = 8'd30;
  localparam logic [7:0] OP_HALT     = 8'd31;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_FETCH,
    ST_READ,
    ST_EXEC,
    ST_WAIT_EX,
    ST_HALT
  } state_e;

  localparam int unsigned INSN_OPC_OFS    = 0;
  localparam int unsigned INSN_RD_OFS     = 1;
  localparam int unsigned INSN_IMM_LO_OFS = 2;
  localparam int unsigned INSN_IMM_HI_OFS = 3;
  localparam int unsigned INSN_BYTES      = 4;

endpackage

// File: rtl/seq_core_alu.sv
// seq_core_alu: combinational add/subtract with zero and carry flags.
//   a_i, b_i : operands
//   sub_i    : 0 = a+b, 1 = a-b
//   res_o    : DATA_W-bit result
//   z_o      : result is zero
//   c_o      : carry out (add) or borrow, i.e. a<b unsigned (sub)
module seq_core_alu #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] res_o,
  output logic              z_o,
  output logic              c_o
);

  logic [DATA_W:0] wide;

  // One extra bit: for subtraction the top bit of the widened difference
  // is set exactly when a < b, so the same bit serves as carry and borrow.
  always_comb begin
    if (sub_i) wide = {1'b0, a_i} - {1'b0, b_i};
    else       wide = {1'b0, a_i} + {1'b0, b_i};
    res_o = wide[DATA_W-1:0];
    c_o   = wide[DATA_W];
    z_o   = (wide[DATA_W-1:0] == '0);
  end

endmodule

// File: rtl/seq_core.sv
// seq_core: byte-RAM instruction sequencer with an external execution unit.
//   clk, reset (async, active-low)
//   run                   : 1 = execute, 0 = load / return to load
//   load_we/addr/data     : byte write port into RAM, honoured in LOAD only
//   ipointer, opcode      : current instruction address and opcode
//   r0, r1                : registered copies of registers 0 and 1
//   debug                 : ram[0] in LOAD, opcode on fetch, reg on op 30
//   halted, fault         : core halted; sticky illegal-opcode/timeout flag
//   ex_req/op/a/b, ex_ack/result : request/acknowledge to external unit
module seq_core
  import seq_core_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NREGS      = 16,
  parameter int RAM_AW     = 8,
  parameter int EX_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              load_we,
  input  logic [RAM_AW-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic [RAM_AW-1:0] ipointer,
  output logic [7:0]        opcode,
  output logic [DATA_W-1:0] r0,
  output logic [DATA_W-1:0] r1,
  output logic [DATA_W-1:0] debug,
  output logic              halted,
  output logic              fault,
  output logic              ex_req,
  output logic [7:0]        ex_op,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  input  logic              ex_ack,
  input  logic [DATA_W-1:0] ex_result
);

  localparam int RW        = $clog2(NREGS);
  localparam int BYTES     = DATA_W / 8;
  localparam int RAM_DEPTH = 1 << RAM_AW;

  logic [7:0]        ram [RAM_DEPTH];
  logic [DATA_W-1:0] rf  [NREGS];

  state_e            state_q, state_d;
  logic [RAM_AW-1:0] ip_q, ip_d;
  logic [7:0]        opc_q, opc_d;
  logic [RW-1:0]     rd_q, rd_d;
  logic [15:0]       imm_q, imm_d;
  logic [DATA_W-1:0] memval_q, memval_d;
  logic [DATA_W-1:0] va_q, va_d;
  logic [DATA_W-1:0] vb_q, vb_d;
  logic              z_q, z_d;
  logic              c_q, c_d;
  logic [DATA_W-1:0] debug_q, debug_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;
  logic              ex_req_q, ex_req_d;
  logic [7:0]        ex_op_q, ex_op_d;
  logic [DATA_W-1:0] ex_a_q, ex_a_d;
  logic [DATA_W-1:0] ex_b_q, ex_b_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] r0_q, r1_q;

  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic              ram_st;

  logic [RAM_AW-1:0] addr;
  logic [RW-1:0]     rs;
  logic [DATA_W-1:0] alu_res;
  logic              alu_z, alu_c;

  assign addr = imm_q[RAM_AW-1:0];
  assign rs   = imm_q[RW-1:0];

  function automatic logic [DATA_W-1:0] zext8(input logic [7:0] b);
    return DATA_W'(b);
  endfunction

  seq_core_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i   (va_q),
    .b_i   (vb_q),
    .sub_i (opc_q != OP_ADD),
    .res_o (alu_res),
    .z_o   (alu_z),
    .c_o   (alu_c)
  );

  always_comb begin
    state_d  = state_q;
    ip_d     = ip_q;
    opc_d    = opc_q;
    rd_d     = rd_q;
    imm_d    = imm_q;
    memval_d = memval_q;
    va_d     = va_q;
    vb_d     = vb_q;
    z_d      = z_q;
    c_d      = c_q;
    debug_d  = debug_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    ex_req_d = ex_req_q;
    ex_op_d  = ex_op_q;
    ex_a_d   = ex_a_q;
    ex_b_d   = ex_b_q;
    cnt_d    = cnt_q;
    rf_we    = 1'b0;
    rf_wdata = '0;
    ram_st   = 1'b0;

    case (state_q)
      ST_LOAD: begin
        debug_d = zext8(ram[0]);
        if (run) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        opc_d   = ram[ip_q + RAM_AW'(INSN_OPC_OFS)];
        rd_d    = ram[ip_q + RAM_AW'(INSN_RD_OFS)][RW-1:0];
        imm_d   = {ram[ip_q + RAM_AW'(INSN_IMM_HI_OFS)],
                   ram[ip_q + RAM_AW'(INSN_IMM_LO_OFS)]};
        debug_d = zext8(ram[ip_q + RAM_AW'(INSN_OPC_OFS)]);
        state_d = ST_READ;
      end

      ST_READ: begin
        for (int k = 0; k < BYTES; k++)
          memval_d[8*k +: 8] = ram[addr + RAM_AW'(k)];
        va_d    = rf[rd_q];
        vb_d    = rf[rs];
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        state_d = ST_FETCH;
        ip_d    = ip_q + RAM_AW'(INSN_BYTES);
        case (opc_q)
          OP_NOP: ;
          OP_MOVI: begin
            rf_we    = 1'b1;
            rf_wdata = DATA_W'(imm_q);
          end
          OP_LD: begin
            rf_we    = 1'b1;
            rf_wdata = memval_q;
          end
          OP_MOV: begin
            rf_we    = 1'b1;
            rf_wdata = vb_q;
          end
          OP_ST: ram_st = 1'b1;
          OP_ADD, OP_SUB: begin
            rf_we    = 1'b1;
            rf_wdata = alu_res;
            z_d      = alu_z;
            c_d      = alu_c;
          end
          OP_CMP: begin
            z_d = alu_z;
            c_d = alu_c;
          end
          OP_JMP: ip_d = addr;
          OP_JZ:  if (z_q)  ip_d = addr;
          OP_JNZ: if (!z_q) ip_d = addr;
          OP_DBG: debug_d = va_q;
          OP_HALT: begin
            ip_d     = ip_q;
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          default: begin
            ip_d = ip_q;
            if (opc_q >= OP_EX_FIRST && opc_q <= OP_EX_LAST) begin
              ex_req_d = 1'b1;
              ex_op_d  = opc_q;
              ex_a_d   = va_q;
              ex_b_d   = vb_q;
              cnt_d    = '0;
              state_d  = ST_WAIT_EX;
            end else begin
              fault_d  = 1'b1;
              halted_d = 1'b1;
              state_d  = ST_HALT;
            end
          end
        endcase
      end

      ST_WAIT_EX: begin
        // Acknowledge wins over a timeout landing in the same cycle.
        if (ex_ack) begin
          rf_we    = 1'b1;
          rf_wdata = ex_result;
          ex_req_d = 1'b0;
          ip_d     = ip_q + RAM_AW'(INSN_BYTES);
          state_d  = ST_FETCH;
        end else if (EX_TIMEOUT != 0 && cnt_q == 32'(EX_TIMEOUT - 1)) begin
          fault_d  = 1'b1;
          ex_req_d = 1'b0;
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      ST_HALT: begin
        halted_d = 1'b1;
        if (!run) begin
          ip_d     = '0;
          halted_d = 1'b0;
          state_d  = ST_LOAD;
        end
      end

      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_LOAD;
      ip_q     <= '0;
      opc_q    <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      memval_q <= '0;
      va_q     <= '0;
      vb_q     <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      debug_q  <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      ex_req_q <= 1'b0;
      ex_op_q  <= '0;
      ex_a_q   <= '0;
      ex_b_q   <= '0;
      cnt_q    <= '0;
      r0_q     <= '0;
      r1_q     <= '0;
    end else begin
      state_q  <= state_d;
      ip_q     <= ip_d;
      opc_q    <= opc_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      memval_q <= memval_d;
      va_q     <= va_d;
      vb_q     <= vb_d;
      z_q      <= z_d;
      c_q      <= c_d;
      debug_q  <= debug_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      ex_req_q <= ex_req_d;
      ex_op_q  <= ex_op_d;
      ex_a_q   <= ex_a_d;
      ex_b_q   <= ex_b_d;
      cnt_q    <= cnt_d;
      r0_q     <= rf[0];
      r1_q     <= rf[1];
    end
  end

  // Register file and RAM keep their contents across reset.
  always_ff @(posedge clk) begin
    if (rf_we) rf[rd_q] <= rf_wdata;
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD && !run && load_we) begin
      ram[load_addr] <= load_data;
    end else if (ram_st) begin
      for (int k = 0; k < BYTES; k++)
        ram[addr + RAM_AW'(k)] <= va_q[8*k +: 8];
    end
  end

  assign ipointer = ip_q;
  assign opcode   = opc_q;
  assign r0       = r0_q;
  assign r1       = r1_q;
  assign debug    = debug_q;
  assign halted   = halted_q;
  assign fault    = fault_q;
  assign ex_req   = ex_req_q;
  assign ex_op    = ex_op_q;
  assign ex_a     = ex_a_q;
  assign ex_b     = ex_b_q;

endmodule
